// File: rtl/regfile_scoreboard.sv
// Register file with hardwired-zero x0, write bypass, per-register pending
// (scoreboard) bits with a reservation handshake, and a sequential bulk clear.
module regfile_scoreboard #(
    parameter int WORDSIZE = 64,
    parameter int SIZE     = 32,
    parameter int AW       = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AW-1:0]       rs1,
    input  logic [AW-1:0]       rs2,
    output logic [WORDSIZE-1:0] rs1_out,
    output logic [WORDSIZE-1:0] rs2_out,
    output logic                rs1_busy,
    output logic                rs2_busy,
    input  logic                we,
    input  logic [AW-1:0]       rd,
    input  logic [WORDSIZE-1:0] rd_in,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ready,
    output logic [AW:0]         pend_count,
    input  logic                clr,
    output logic                clr_busy,
    input  logic [AW-1:0]       dbg_addr,
    output logic [WORDSIZE-1:0] dbg_data
);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_CLEAR = 1'b1;
    localparam logic [AW:0]   SIZE_W   = (AW+1)'(SIZE);
    localparam logic [AW-1:0] LAST_IDX = AW'(SIZE - 1);
    localparam logic [AW-1:0] ONE_IDX  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};

    logic [WORDSIZE-1:0] r_regs [SIZE];
    logic [SIZE-1:0]     r_pend;
    logic [AW:0]         r_pend_count;
    logic [0:0]          r_state;
    logic [AW-1:0]       r_clr_idx;
    logic [WORDSIZE-1:0] r_dbg_data;

    logic                w_idle;
    logic                w_wr;
    logic                w_acc;
    logic                w_dec;
    logic [SIZE-1:0]     w_clr_mask;
    logic [SIZE-1:0]     w_set_mask;
    logic [SIZE-1:0]     w_pend_nxt;
    logic [AW:0]         w_cnt_nxt;

    // An address is architecturally live when nonzero and inside the array.
    function automatic logic f_valid(input logic [AW-1:0] a);
        f_valid = (a != ZERO_IDX) && ({1'b0, a} < SIZE_W);
    endfunction

    assign w_idle = (r_state == ST_IDLE);
    assign w_wr   = w_idle && we && f_valid(rd);

    assign rsv_ready = w_idle && (!f_valid(rsv_addr) || !r_pend[rsv_addr] ||
                                  (w_wr && (rd == rsv_addr)));
    assign w_acc     = rsv_valid && rsv_ready && f_valid(rsv_addr);

    // Write clears its pending bit before a same-cycle reservation sets one.
    always_comb begin
        w_dec      = w_wr && r_pend[rd];
        w_clr_mask = w_wr  ? ({{(SIZE-1){1'b0}}, 1'b1} << rd)       : {SIZE{1'b0}};
        w_set_mask = w_acc ? ({{(SIZE-1){1'b0}}, 1'b1} << rsv_addr) : {SIZE{1'b0}};
        w_pend_nxt = (r_pend & ~w_clr_mask) | w_set_mask;
        w_cnt_nxt  = r_pend_count + (AW+1)'(w_acc) - (AW+1)'(w_dec);
    end

    // Read ports: zero for x0/out-of-range, bypass only from an IDLE write.
    always_comb begin
        rs1_out  = {WORDSIZE{1'b0}};
        rs1_busy = 1'b0;
        if (f_valid(rs1)) begin
            rs1_out  = (w_wr && (rd == rs1)) ? rd_in : r_regs[rs1];
            rs1_busy = r_pend[rs1] && !(w_wr && (rd == rs1));
        end else begin
            rs1_out  = {WORDSIZE{1'b0}};
            rs1_busy = 1'b0;
        end
    end

    // Second read port, identical to the first.
    always_comb begin
        rs2_out  = {WORDSIZE{1'b0}};
        rs2_busy = 1'b0;
        if (f_valid(rs2)) begin
            rs2_out  = (w_wr && (rd == rs2)) ? rd_in : r_regs[rs2];
            rs2_busy = r_pend[rs2] && !(w_wr && (rd == rs2));
        end else begin
            rs2_out  = {WORDSIZE{1'b0}};
            rs2_busy = 1'b0;
        end
    end

    // Control FSM, scoreboard bits and clear-sweep index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_clr_idx    <= ONE_IDX;
            r_pend       <= {SIZE{1'b0}};
            r_pend_count <= {(AW+1){1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr) begin
                        r_state      <= ST_CLEAR;
                        r_pend       <= {SIZE{1'b0}};
                        r_pend_count <= {(AW+1){1'b0}};
                    end else begin
                        r_pend       <= w_pend_nxt;
                        r_pend_count <= w_cnt_nxt;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_idx == LAST_IDX) begin
                        r_state   <= ST_IDLE;
                        r_clr_idx <= ONE_IDX;
                    end else begin
                        r_clr_idx <= r_clr_idx + ONE_IDX;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_clr_idx <= ONE_IDX;
                end
            endcase
        end
    end

    // Register array: normal writes in IDLE, one zeroing per cycle in CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SIZE; k++) begin
                r_regs[k] <= {WORDSIZE{1'b0}};
            end
        end else if (w_wr) begin
            r_regs[rd] <= rd_in;
        end else if (r_state == ST_CLEAR) begin
            r_regs[r_clr_idx] <= {WORDSIZE{1'b0}};
        end else begin
            r_regs[0] <= {WORDSIZE{1'b0}};
        end
    end

    // Debug port samples raw array content, no bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbg_data <= {WORDSIZE{1'b0}};
        end else if (f_valid(dbg_addr)) begin
            r_dbg_data <= r_regs[dbg_addr];
        end else begin
            r_dbg_data <= {WORDSIZE{1'b0}};
        end
    end

    assign pend_count = r_pend_count;
    assign clr_busy   = (r_state == ST_CLEAR);
    assign dbg_data   = r_dbg_data;

endmodule
